// File: rtl/ap_mon_pkg.sv
// Shared FSM state type and readout field map for the ap_ctrl performance monitor.
package ap_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ap_state_e;

    localparam int RD_FIELDS = 8;

    localparam logic [2:0] RD_TXN   = 3'd0;
    localparam logic [2:0] RD_LAST  = 3'd1;
    localparam logic [2:0] RD_MIN   = 3'd2;
    localparam logic [2:0] RD_MAX   = 3'd3;
    localparam logic [2:0] RD_STALL = 3'd4;
    localparam logic [2:0] RD_READY = 3'd5;
    localparam logic [2:0] RD_STATE = 3'd6;
    localparam logic [2:0] RD_ZERO  = 3'd7;

endpackage

// File: rtl/ap_mon_channel.sv
// One ap_ctrl channel: handshake FSM, latency timing and saturating statistics.
module ap_mon_channel
    import ap_mon_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold_i,
    input  logic             start_i,
    input  logic             ready_i,
    input  logic             done_i,
    input  logic             cont_i,
    output ap_state_e        state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] txn_o,
    output logic [CNT_W-1:0] last_o,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o,
    output logic [CNT_W-1:0] stall_o,
    output logic [CNT_W-1:0] ready_o
);

    localparam logic [63:0]      CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
    localparam bit               TO_REACH = (64'(TIMEOUT) <= CNT_MAX);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAT_ONE  = CNT_W'(1);

    ap_state_e        state_q;
    logic             timeout_q;
    logic [CNT_W-1:0] lat_q, txn_q, last_q, min_q, max_q, stall_q, ready_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + LAT_ONE;
    endfunction

    // lat_q always holds the count for the current cycle, so the flag is
    // evaluated against the count the channel is about to enter.
    function automatic logic reach(input logic [CNT_W-1:0] v);
        return TO_REACH && (v >= TO_VAL);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            timeout_q <= 1'b0;
            lat_q     <= '0;
            txn_q     <= '0;
            last_q    <= '0;
            min_q     <= '1;
            max_q     <= '0;
            stall_q   <= '0;
            ready_q   <= '0;
        end else if (!hold_i) begin
            if (ready_i) ready_q <= sat_inc(ready_q);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= RUN;
                        lat_q     <= LAT_ONE;
                        timeout_q <= timeout_q | reach(LAT_ONE);
                    end
                end
                RUN: begin
                    if (done_i) begin
                        txn_q  <= sat_inc(txn_q);
                        last_q <= lat_q;
                        if (lat_q < min_q) min_q <= lat_q;
                        if (lat_q > max_q) max_q <= lat_q;
                        if (!cont_i) begin
                            state_q <= HOLD;
                            lat_q   <= '0;
                        end else if (start_i) begin
                            lat_q     <= LAT_ONE;
                            timeout_q <= timeout_q | reach(LAT_ONE);
                        end else begin
                            state_q <= IDLE;
                            lat_q   <= '0;
                        end
                    end else begin
                        lat_q     <= sat_inc(lat_q);
                        timeout_q <= timeout_q | reach(sat_inc(lat_q));
                    end
                end
                default: begin
                    if (cont_i) begin
                        if (start_i) begin
                            state_q   <= RUN;
                            lat_q     <= LAT_ONE;
                            timeout_q <= timeout_q | reach(LAT_ONE);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        stall_q <= sat_inc(stall_q);
                    end
                end
            endcase
        end
    end

    assign state_o   = state_q;
    assign timeout_o = timeout_q;
    assign txn_o     = txn_q;
    assign last_o    = last_q;
    assign min_o     = min_q;
    assign max_o     = max_q;
    assign stall_o   = stall_q;
    assign ready_o   = ready_q;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl performance monitor with freeze-on-finish and a registered readout port.
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = 32,
    parameter int  TIMEOUT = 100000,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SEL_W   = $clog2(RD_FIELDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] timeout,
    output logic              all_idle
);

    ap_state_e        st    [NUM_CH];
    logic [CNT_W-1:0] txn   [NUM_CH];
    logic [CNT_W-1:0] last  [NUM_CH];
    logic [CNT_W-1:0] mn    [NUM_CH];
    logic [CNT_W-1:0] mx    [NUM_CH];
    logic [CNT_W-1:0] stall [NUM_CH];
    logic [CNT_W-1:0] rdy   [NUM_CH];
    logic [CNT_W-1:0] rd_d, rd_q;
    logic             frozen_q;
    logic             hold;

    // The finish cycle itself is already frozen, hence the OR with the live input.
    assign hold = finish | frozen_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            frozen_q <= 1'b0;
        end else if (finish) begin
            frozen_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ap_mon_channel #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .hold_i    (hold),
            .start_i   (ap_start[i]),
            .ready_i   (ap_ready[i]),
            .done_i    (ap_done[i]),
            .cont_i    (ap_continue[i]),
            .state_o   (st[i]),
            .timeout_o (timeout[i]),
            .txn_o     (txn[i]),
            .last_o    (last[i]),
            .min_o     (mn[i]),
            .max_o     (mx[i]),
            .stall_o   (stall[i]),
            .ready_o   (rdy[i])
        );
    end

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (st[i] != IDLE) all_idle = 1'b0;
        end
    end

    always_comb begin
        rd_d = '0;
        if (32'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                RD_TXN:   rd_d = txn[rd_ch];
                RD_LAST:  rd_d = last[rd_ch];
                RD_MIN:   rd_d = mn[rd_ch];
                RD_MAX:   rd_d = mx[rd_ch];
                RD_STALL: rd_d = stall[rd_ch];
                RD_READY: rd_d = rdy[rd_ch];
                RD_STATE: rd_d = CNT_W'({st[rd_ch], timeout[rd_ch]});
                RD_ZERO:  rd_d = '0;
                default:  rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench for ap_ctrl_perf_monitor: cycle-level reference model plus literal readout checks.
module tb_ap_ctrl_perf_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        m_finish, s_finish;
    logic [3:0]  m_start, m_ready, m_done, m_cont;
    logic [2:0]  s_start, s_ready, s_done, s_cont;
    logic [1:0]  m_rd_ch, s_rd_ch;
    logic [2:0]  m_rd_sel, s_rd_sel;
    logic [31:0] m_rd_data;
    logic [3:0]  s_rd_data;
    logic [3:0]  m_timeout;
    logic [2:0]  s_timeout;
    logic        m_all_idle, s_all_idle;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .TIMEOUT(20)) u_main (
        .clock(clock), .reset(reset), .finish(m_finish),
        .ap_start(m_start), .ap_ready(m_ready), .ap_done(m_done), .ap_continue(m_cont),
        .rd_ch(m_rd_ch), .rd_sel(m_rd_sel), .rd_data(m_rd_data),
        .timeout(m_timeout), .all_idle(m_all_idle)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(3), .CNT_W(4), .TIMEOUT(10)) u_small (
        .clock(clock), .reset(reset), .finish(s_finish),
        .ap_start(s_start), .ap_ready(s_ready), .ap_done(s_done), .ap_continue(s_cont),
        .rd_ch(s_rd_ch), .rd_sel(s_rd_sel), .rd_data(s_rd_data),
        .timeout(s_timeout), .all_idle(s_all_idle)
    );

    // Reference model: a transaction is its acceptance cycle number, latency is elapsed cycles.
    typedef struct {
        int     st;
        longint acc, txn, last, mn, mx, stall, rdy;
        bit     tflag;
    } mch_t;

    mch_t   mdl [2][4];
    bit     frz [2];
    longint exp_rd [2];
    longint cyc = 0;

    function automatic longint mx_of(input int k);
        return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
    endfunction
    function automatic int nc_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction
    function automatic int to_of(input int k);
        return (k == 0) ? 20 : 10;
    endfunction
    function automatic longint inc(input longint v, input longint m);
        return (v + 1 > m) ? m : v + 1;
    endfunction

    function automatic longint field(input int k, input int ch, input int sel);
        if (ch >= nc_of(k)) return 0;
        case (sel)
            0: return mdl[k][ch].txn;
            1: return mdl[k][ch].last;
            2: return mdl[k][ch].mn;
            3: return mdl[k][ch].mx;
            4: return mdl[k][ch].stall;
            5: return mdl[k][ch].rdy;
            6: return longint'(mdl[k][ch].st * 2) + longint'(mdl[k][ch].tflag);
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_to(input int k);
        logic [3:0] v = 4'd0;
        for (int i = 0; i < nc_of(k); i++) v[i] = mdl[k][i].tflag;
        return v;
    endfunction

    function automatic logic exp_idle(input int k);
        logic v = 1'b1;
        for (int i = 0; i < nc_of(k); i++) if (mdl[k][i].st != 0) v = 1'b0;
        return v;
    endfunction

    task automatic mdl_step(input int k, input bit rst, input bit fin,
                            input logic [3:0] s, input logic [3:0] r,
                            input logic [3:0] d, input logic [3:0] c,
                            input int rch, input int rsel);
        longint m, lat;
        m = mx_of(k);
        if (rst) begin
            frz[k] = 1'b0;
            exp_rd[k] = 0;
            for (int i = 0; i < 4; i++) begin
                mdl[k][i].st = 0;   mdl[k][i].acc = 0;  mdl[k][i].txn = 0;
                mdl[k][i].last = 0; mdl[k][i].mn = m;   mdl[k][i].mx = 0;
                mdl[k][i].stall = 0; mdl[k][i].rdy = 0; mdl[k][i].tflag = 1'b0;
            end
            return;
        end
        exp_rd[k] = field(k, rch, rsel);
        if (frz[k] || fin) begin
            frz[k] = 1'b1;
            return;
        end
        for (int i = 0; i < nc_of(k); i++) begin
            lat = cyc - mdl[k][i].acc;
            if (lat > m) lat = m;
            if (r[i]) mdl[k][i].rdy = inc(mdl[k][i].rdy, m);
            case (mdl[k][i].st)
                0: if (s[i]) begin mdl[k][i].st = 1; mdl[k][i].acc = cyc; end
                1: if (d[i]) begin
                    mdl[k][i].txn  = inc(mdl[k][i].txn, m);
                    mdl[k][i].last = lat;
                    if (lat < mdl[k][i].mn) mdl[k][i].mn = lat;
                    if (lat > mdl[k][i].mx) mdl[k][i].mx = lat;
                    if (!c[i])     mdl[k][i].st = 2;
                    else if (s[i]) mdl[k][i].acc = cyc;
                    else           mdl[k][i].st = 0;
                end
                default: begin
                    if (c[i]) begin
                        if (s[i]) begin mdl[k][i].st = 1; mdl[k][i].acc = cyc; end
                        else mdl[k][i].st = 0;
                    end else begin
                        mdl[k][i].stall = inc(mdl[k][i].stall, m);
                    end
                end
            endcase
            if (mdl[k][i].st == 1 && longint'(to_of(k)) <= m &&
                (cyc + 1 - mdl[k][i].acc) >= longint'(to_of(k)))
                mdl[k][i].tflag = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        mdl_step(0, reset, m_finish, m_start, m_ready, m_done, m_cont, int'(m_rd_ch), int'(m_rd_sel));
        mdl_step(1, reset, s_finish, {1'b0, s_start}, {1'b0, s_ready}, {1'b0, s_done},
                 {1'b0, s_cont}, int'(s_rd_ch), int'(s_rd_sel));
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("main_rd_data", 64'(m_rd_data), exp_rd[0]);
            chk("main_timeout", 64'(m_timeout), 64'(exp_to(0)));
            chk("main_all_idle", 64'(m_all_idle), 64'(exp_idle(0)));
            chk("small_rd_data", 64'(s_rd_data), exp_rd[1]);
            chk("small_timeout", 64'(s_timeout), 64'(exp_to(1) & 4'b0111));
            chk("small_all_idle", 64'(s_all_idle), 64'(exp_idle(1)));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic read_chk(input int k, input int ch, input int sel, input longint exp, input string nm);
        if (k == 0) begin
            m_rd_ch = 2'(ch);
            m_rd_sel = 3'(sel);
        end else begin
            s_rd_ch = 2'(ch);
            s_rd_sel = 3'(sel);
        end
        tick();
        chk(nm, (k == 0) ? 64'(m_rd_data) : 64'(s_rd_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset = 1'b1;
        m_finish = 1'b0; s_finish = 1'b0;
        m_start = '0; m_ready = '0; m_done = '0; m_cont = '1;
        s_start = '0; s_ready = '0; s_done = '0; s_cont = '1;
        m_rd_ch = '0; m_rd_sel = '0; s_rd_ch = '0; s_rd_sel = '0;
        repeat (3) tick();
        chk("rst_all_idle", 64'(m_all_idle), 64'd1);
        chk("rst_timeout", 64'(m_timeout), 64'd0);
        chk("rst_rd_data", 64'(m_rd_data), 64'd0);
        chk_en = 1'b1;
        reset = 1'b0;
        read_chk(0, 0, 2, 64'hFFFF_FFFF, "rst_min_lat");

        // ch0: latency 7 with immediate continue
        m_start[0] = 1'b1; tick(); m_start[0] = 1'b0;
        repeat (6) tick();
        m_done[0] = 1'b1; tick(); m_done[0] = 1'b0;
        chk("c0_all_idle", 64'(m_all_idle), 64'd1);
        read_chk(0, 0, 0, 1, "c0_txn");
        read_chk(0, 0, 1, 7, "c0_last");
        read_chk(0, 0, 2, 7, "c0_min");
        read_chk(0, 0, 3, 7, "c0_max");
        read_chk(0, 0, 6, 0, "c0_state");

        // ch1: latency 4, then three stalled HOLD cycles
        m_start[1] = 1'b1; tick(); m_start[1] = 1'b0;
        repeat (3) tick();
        m_done[1] = 1'b1; m_cont[1] = 1'b0; m_rd_ch = 2'd1; m_rd_sel = 3'd6;
        tick(); m_done[1] = 1'b0;
        repeat (3) tick();
        chk("c1_hold_state", 64'(m_rd_data), 64'd4);
        chk("c1_hold_busy", 64'(m_all_idle), 64'd0);
        m_cont[1] = 1'b1; tick();
        read_chk(0, 1, 4, 3, "c1_stall");
        read_chk(0, 1, 1, 4, "c1_last");
        read_chk(0, 1, 6, 0, "c1_state");

        // ch2: back-to-back latencies 3 and 6
        m_start[2] = 1'b1; tick(); m_start[2] = 1'b0;
        repeat (2) tick();
        m_start[2] = 1'b1; m_done[2] = 1'b1; tick();
        m_start[2] = 1'b0; m_done[2] = 1'b0;
        chk("c2_no_idle", 64'(m_all_idle), 64'd0);
        repeat (5) tick();
        m_done[2] = 1'b1; tick(); m_done[2] = 1'b0;
        read_chk(0, 2, 0, 2, "c2_txn");
        read_chk(0, 2, 2, 3, "c2_min");
        read_chk(0, 2, 3, 6, "c2_max");
        read_chk(0, 2, 1, 6, "c2_last");

        m_ready[0] = 1'b1; repeat (3) tick(); m_ready[0] = 1'b0;
        read_chk(0, 0, 5, 3, "c0_ready");

        // ch3: never done, flag at count 20
        m_start[3] = 1'b1; tick(); m_start[3] = 1'b0;
        repeat (18) tick();
        chk("c3_to_before", 64'(m_timeout), 64'd0);
        tick();
        chk("c3_to_set", 64'(m_timeout), 64'd8);
        chk("c3_busy", 64'(m_all_idle), 64'd0);
        read_chk(0, 3, 6, 3, "c3_state");
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_timeout", 64'(m_timeout), 64'd0);
        chk("rst2_all_idle", 64'(m_all_idle), 64'd1);
        read_chk(0, 3, 2, 64'hFFFF_FFFF, "rst2_min_c3");
        read_chk(0, 0, 0, 0, "rst2_txn_c0");

        // small instance: saturation at 15
        s_start[0] = 1'b1; tick();
        s_done[0] = 1'b1; repeat (19) tick();
        s_start[0] = 1'b0; tick(); s_done[0] = 1'b0;
        read_chk(1, 0, 0, 15, "sat_txn");
        read_chk(1, 0, 1, 1, "sat_last");
        s_ready[2] = 1'b1; repeat (20) tick(); s_ready[2] = 1'b0;
        read_chk(1, 2, 5, 15, "sat_ready");
        s_start[1] = 1'b1; tick(); s_start[1] = 1'b0;
        repeat (9) tick();
        chk("small_to_set", 64'(s_timeout), 64'd2);
        repeat (15) tick();
        s_done[1] = 1'b1; tick(); s_done[1] = 1'b0;
        read_chk(1, 1, 1, 15, "sat_lat");
        read_chk(1, 2, 2, 15, "small_min_c2");
        read_chk(1, 3, 2, 0, "small_oob");

        // finish freezes ch0 mid-RUN
        m_start[0] = 1'b1; tick(); m_start[0] = 1'b0;
        repeat (2) tick();
        m_done[0] = 1'b1; tick(); m_done[0] = 1'b0;
        m_start[0] = 1'b1; tick(); m_start[0] = 1'b0; tick();
        m_finish = 1'b1; tick(); m_finish = 1'b0;
        m_done[0] = 1'b1; m_ready[0] = 1'b1; repeat (3) tick();
        m_done[0] = 1'b0; m_ready[0] = 1'b0;
        read_chk(0, 0, 0, 1, "fin_txn");
        read_chk(0, 0, 1, 3, "fin_last");
        read_chk(0, 0, 5, 0, "fin_ready");
        read_chk(0, 0, 6, 2, "fin_state");
        chk("fin_busy", 64'(m_all_idle), 64'd0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
